// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: divider FSM
// state encoding, default divider latency and the stall-cause ordering.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int unsigned DIV_CYCLES_DEFAULT = 32;
   localparam int unsigned CNT_W_DEFAULT      = 6;

   // Stall causes listed from highest to lowest priority; the numeric
   // value doubles as the rank (lower value wins).
   typedef enum logic [2:0] {
      CAUSE_NONE     = 3'd0,
      CAUSE_EXC      = 3'd1,
      CAUSE_MEM      = 3'd2,
      CAUSE_DIV      = 3'd3,
      CAUSE_LOAD_USE = 3'd4,
      CAUSE_BRANCH   = 3'd5
   } stall_cause_e;

   // Resolves simultaneous hazards down to the single one that governs
   // the pipeline this cycle; lower-ranked hazards are re-evaluated once
   // the winning one clears.
   function automatic stall_cause_e pick_cause(input logic exc,
                                               input logic mem,
                                               input logic div,
                                               input logic load_use,
                                               input logic branch);
      stall_cause_e cause;
      cause = CAUSE_NONE;
      if (exc)
         cause = CAUSE_EXC;
      else if (mem)
         cause = CAUSE_MEM;
      else if (div)
         cause = CAUSE_DIV;
      else if (load_use)
         cause = CAUSE_LOAD_USE;
      else if (branch)
         cause = CAUSE_BRANCH;
      return cause;
   endfunction

endpackage

// File: rtl/div_seq.sv
// Multi-cycle divider sequencer: tracks IDLE/RUN/DONE and the remaining
// iteration count, and tells the hazard logic when EX must be held.
module div_seq
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
   parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic ex_div_start,
   input  logic exc_flush,
   input  logic advance,
   output logic div_stall,
   output logic div_busy,
   output logic div_done
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state and counter update; an exception abandons any division,
   // and the counter is only loaded from IDLE so it can never wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (exc_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ex_div_start) begin
                  state_d = RUN;
                  cnt_d   = CNT_W'(DIV_CYCLES - 1);
               end
            end
            RUN: begin
               if (cnt_q == '0)
                  state_d = DONE;
               else
                  cnt_d = cnt_q - CNT_W'(1);
            end
            DONE: begin
               if (advance)
                  state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // EX is held while a new divide is being accepted and while it runs;
   // it advances in the DONE cycle.
   always_comb begin
      div_stall = ((state_q == IDLE) && ex_div_start) || (state_q == RUN);
      div_busy  = (state_q == RUN);
      div_done  = (state_q == DONE);
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: hazard detection
// and the priority mux driving PC and stage-register enables/flushes.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
   parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] ex_rt,
   input  logic       ex_memread,
   input  logic       id_branch_taken,
   input  logic       ex_div_start,
   input  logic       mem_req,
   input  logic       mem_ready,
   input  logic       exc_flush,
   output logic       pc_en,
   output logic       en_if_id,
   output logic       en_id_ex,
   output logic       en_ex_mem,
   output logic       en_mem_wb,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       flush_ex_mem,
   output logic       flush_mem_wb,
   output logic       div_busy,
   output logic       div_done
);

   logic         mem_stall;
   logic         load_use;
   logic         div_stall;
   logic         seq_busy;
   logic         seq_done;
   logic         advance;
   stall_cause_e cause;

   // Raw hazard terms: memory wait and a load feeding the next instruction
   // (register 0 never creates a dependency).
   always_comb begin
      mem_stall = mem_req & ~mem_ready;
      load_use  = ex_memread & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));
      advance   = en_ex_mem & ~mem_stall;
      cause     = pick_cause(exc_flush, mem_stall, div_stall, load_use,
                             id_branch_taken);
   end

   div_seq #(
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_div_seq (
      .clk          (clk),
      .rst          (rst),
      .ex_div_start (ex_div_start),
      .exc_flush    (exc_flush),
      .advance      (advance),
      .div_stall    (div_stall),
      .div_busy     (seq_busy),
      .div_done     (seq_done)
   );

   // Priority mux: reset clears every stage and freezes the PC, otherwise
   // the single winning hazard decides which enables drop and which
   // registers receive a bubble.
   always_comb begin
      pc_en        = 1'b1;
      en_if_id     = 1'b1;
      en_id_ex     = 1'b1;
      en_ex_mem    = 1'b1;
      en_mem_wb    = 1'b1;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      flush_mem_wb = 1'b0;
      div_busy     = seq_busy & ~rst;
      div_done     = seq_done & ~rst;
      if (rst) begin
         pc_en        = 1'b0;
         flush_if_id  = 1'b1;
         flush_id_ex  = 1'b1;
         flush_ex_mem = 1'b1;
         flush_mem_wb = 1'b1;
      end else begin
         case (cause)
            CAUSE_EXC: begin
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
               flush_mem_wb = 1'b1;
            end
            CAUSE_MEM: begin
               pc_en        = 1'b0;
               en_if_id     = 1'b0;
               en_id_ex     = 1'b0;
               en_ex_mem    = 1'b0;
               flush_mem_wb = 1'b1;
            end
            CAUSE_DIV: begin
               pc_en        = 1'b0;
               en_if_id     = 1'b0;
               en_id_ex     = 1'b0;
               flush_ex_mem = 1'b1;
            end
            CAUSE_LOAD_USE: begin
               pc_en       = 1'b0;
               en_if_id    = 1'b0;
               flush_id_ex = 1'b1;
            end
            CAUSE_BRANCH: begin
               flush_if_id = 1'b1;
            end
            default: begin
               pc_en = 1'b1;
            end
         endcase
      end
   end

endmodule
